// File: rtl/time_field_bank.sv
// Bank of BCD time fields fed by RTC reads (run mode) or user edits (edit mode),
// with a valid/ready write-back of edited fields when edit mode is left.
module time_field_bank #(
  parameter int                        NUM_FIELDS = 3,
  parameter int                        AW         = 2,
  parameter logic [NUM_FIELDS*8-1:0]   FIELD_MAX  = {8'h23, 8'h59, 8'h59}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seleccion,
  input  logic                      en_deco,
  input  logic                      rtc_valid,
  input  logic [AW-1:0]             rtc_addr,
  input  logic [7:0]                rtc_data,
  input  logic [AW-1:0]             edit_field,
  input  logic                      act,
  input  logic [7:0]                act_data,
  input  logic                      edit_inc,
  input  logic                      edit_dec,
  input  logic                      wb_ready,
  output logic [NUM_FIELDS*8-1:0]   fields,
  output logic [NUM_FIELDS-1:0]     dirty,
  output logic                      wb_valid,
  output logic [AW-1:0]             wb_addr,
  output logic [7:0]                wb_data,
  output logic                      wb_busy,
  output logic                      wb_done
);

  // state  | meaning
  // S_IDLE | no write-back in progress; loads and edits allowed
  // S_SEND | presenting dirty field idx_q as a write-back beat
  // S_DONE | one-cycle wb_done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [AW:0] NF = (AW+1)'(NUM_FIELDS);

  state_t                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic                    seleccion_q, seleccion_d;
  logic [7:0]              field_q [NUM_FIELDS];
  logic [7:0]              field_d [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]   dirty_q, dirty_d;
  logic [NUM_FIELDS-1:0]   dirty_rem;

  logic                    idle;
  logic                    rtc_in_range;
  logic                    edit_in_range;
  logic [7:0]              edit_cur;
  logic [7:0]              edit_max;
  logic [7:0]              edit_val;
  logic                    edit_wr;

  function automatic logic [AW-1:0] lowest_set(input logic [NUM_FIELDS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_FIELDS-1; i >= 0; i--) begin
      if (v[i]) lowest_set = AW'(i);
    end
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
    if (v == mx)                 bcd_inc = 8'h00;
    else if (v[3:0] == 4'd9)     bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                         bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
    if (v == 8'h00)              bcd_dec = mx;
    else if (v[3:0] == 4'd0)     bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                         bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] mx);
    bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= mx);
  endfunction

  assign idle          = (state_q == S_IDLE);
  assign seleccion_d   = seleccion;
  assign rtc_in_range  = ({1'b0, rtc_addr}   < NF);
  assign edit_in_range = ({1'b0, edit_field} < NF);

  // Selected field value and its limit, decoded without out-of-range indexing
  always_comb begin
    edit_cur = 8'h00;
    edit_max = 8'h00;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (edit_field == AW'(i)) begin
        edit_cur = field_q[i];
        edit_max = FIELD_MAX[8*i +: 8];
      end
    end
  end

  // act has priority; a rejected act still suppresses inc/dec
  always_comb begin
    edit_val = edit_cur;
    edit_wr  = 1'b0;
    if (act) begin
      if (bcd_ok(act_data, edit_max)) begin
        edit_val = act_data;
        edit_wr  = 1'b1;
      end
    end else if (edit_inc && !edit_dec) begin
      edit_val = bcd_inc(edit_cur, edit_max);
      edit_wr  = 1'b1;
    end else if (edit_dec && !edit_inc) begin
      edit_val = bcd_dec(edit_cur, edit_max);
      edit_wr  = 1'b1;
    end
  end

  always_comb begin
    field_d = field_q;
    dirty_d = dirty_q;
    if (en_deco && idle) begin
      if (!seleccion && rtc_valid && rtc_in_range) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (rtc_addr == AW'(i)) field_d[i] = rtc_data;
        end
      end else if (seleccion && edit_in_range && edit_wr) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (edit_field == AW'(i)) begin
            field_d[i] = edit_val;
            dirty_d[i] = 1'b1;
          end
        end
      end
    end
    if (state_q == S_SEND && wb_ready) dirty_d[idx_q] = 1'b0;
  end

  always_comb begin
    dirty_rem        = dirty_q;
    dirty_rem[idx_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (seleccion_q && !seleccion && (|dirty_q)) begin
          state_d = S_SEND;
          idx_d   = lowest_set(dirty_q);
        end
      end
      S_SEND: begin
        if (wb_ready) begin
          if (|dirty_rem) idx_d   = lowest_set(dirty_rem);
          else            state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_valid = (state_q == S_SEND);
    wb_addr  = '0;
    wb_data  = 8'h00;
    wb_busy  = !idle;
    wb_done  = (state_q == S_DONE);
    if (state_q == S_SEND) begin
      wb_addr = idx_q;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (idx_q == AW'(i)) wb_data = field_q[i];
      end
    end
  end

  always_comb begin
    fields = '0;
    for (int i = 0; i < NUM_FIELDS; i++) fields[8*i +: 8] = field_q[i];
  end

  assign dirty = dirty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      seleccion_q <= 1'b0;
      dirty_q     <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) field_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seleccion_q <= seleccion_d;
      dirty_q     <= dirty_d;
      for (int i = 0; i < NUM_FIELDS; i++) field_q[i] <= field_d[i];
    end
  end

endmodule

// File: tb/tb_time_field_bank.sv
// Directed bench for time_field_bank: field values checked inline, write-back
// beats checked by a scoreboard monitor fed from the stimulus thread.
module tb_time_field_bank;

  logic        clk;
  logic        reset;
  logic        seleccion;
  logic        en_deco;
  logic        rtc_valid;
  logic [1:0]  rtc_addr;
  logic [7:0]  rtc_data;
  logic [1:0]  edit_field;
  logic        act;
  logic [7:0]  act_data;
  logic        edit_inc;
  logic        edit_dec;
  logic        wb_ready;
  logic [23:0] fields;
  logic [2:0]  dirty;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        wb_busy;
  logic        wb_done;

  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] sb_q [$];

  time_field_bank dut (
    .clk        (clk),
    .reset      (reset),
    .seleccion  (seleccion),
    .en_deco    (en_deco),
    .rtc_valid  (rtc_valid),
    .rtc_addr   (rtc_addr),
    .rtc_data   (rtc_data),
    .edit_field (edit_field),
    .act        (act),
    .act_data   (act_data),
    .edit_inc   (edit_inc),
    .edit_dec   (edit_dec),
    .wb_ready   (wb_ready),
    .fields     (fields),
    .dirty      (dirty),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_busy    (wb_busy),
    .wb_done    (wb_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Beats are compared mid-cycle, where the values seen match the next accepting edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && wb_valid && wb_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL wb_unexpected_beat: got addr %0h data %0h expected none", wb_addr, wb_data);
        end else begin
          logic [9:0] e;
          e = sb_q.pop_front();
          check("wb_beat_addr", 32'(wb_addr), 32'(e[9:8]));
          check("wb_beat_data", 32'(wb_data), 32'(e[7:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rtc_wr(input logic [1:0] a, input logic [7:0] d);
    rtc_valid = 1'b1; rtc_addr = a; rtc_data = d;
    tick();
    rtc_valid = 1'b0;
  endtask

  task automatic edit(input logic [1:0] f, input logic a, input logic [7:0] ad,
                      input logic inc, input logic dec);
    edit_field = f; act = a; act_data = ad; edit_inc = inc; edit_dec = dec;
    tick();
    act = 1'b0; edit_inc = 1'b0; edit_dec = 1'b0;
  endtask

  initial begin
    reset = 1'b1; seleccion = 1'b0; en_deco = 1'b1; rtc_valid = 1'b0;
    rtc_addr = '0; rtc_data = '0; edit_field = '0; act = 1'b0; act_data = '0;
    edit_inc = 1'b0; edit_dec = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_fields",   32'(fields),   32'h0);
    check("rst_dirty",    32'(dirty),    32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_wb_addr",  32'(wb_addr),  32'h0);
    check("rst_wb_data",  32'(wb_data),  32'h0);
    check("rst_wb_busy",  32'(wb_busy),  32'h0);
    check("rst_wb_done",  32'(wb_done),  32'h0);

    // run-mode RTC loads
    rtc_wr(2'd1, 8'h42);
    check("rtc_load_f1",  32'(fields), 32'h004200);
    check("rtc_load_dirty", 32'(dirty), 32'h0);
    en_deco = 1'b0;
    rtc_wr(2'd1, 8'h11);
    en_deco = 1'b1;
    check("rtc_gated_en", 32'(fields), 32'h004200);
    rtc_wr(2'd3, 8'h99);
    check("rtc_oor_addr", 32'(fields), 32'h004200);
    rtc_wr(2'd0, 8'h59);
    rtc_wr(2'd2, 8'h19);
    check("rtc_load_f0_f2", 32'(fields), 32'h194259);

    // edit session 1
    seleccion = 1'b1;
    tick();
    edit(2'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("inc_wrap_59", 32'(fields), 32'h194200);
    check("inc_dirty_f0", 32'(dirty), 32'h1);
    edit(2'd2, 1'b0, 8'h00, 1'b1, 1'b0);
    check("inc_carry_19", 32'(fields), 32'h204200);
    check("inc_dirty_f2", 32'(dirty), 32'h5);
    edit(2'd2, 1'b1, 8'h23, 1'b0, 1'b0);
    check("act_23_f2",    32'(fields), 32'h234200);
    edit(2'd2, 1'b0, 8'h00, 1'b1, 1'b0);
    check("inc_wrap_23",  32'(fields), 32'h004200);
    edit(2'd0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("inc_dec_both", 32'(fields), 32'h004200);
    check("inc_dec_dirty", 32'(dirty), 32'h5);
    edit(2'd1, 1'b1, 8'h6A, 1'b0, 1'b0);
    check("act_bad_nibble", 32'(fields), 32'h004200);
    edit(2'd1, 1'b1, 8'h60, 1'b0, 1'b0);
    check("act_over_max", 32'(fields), 32'h004200);
    check("act_rej_dirty", 32'(dirty), 32'h5);
    edit(2'd3, 1'b0, 8'h00, 1'b1, 1'b0);
    check("edit_oor_addr", 32'(fields), 32'h004200);
    edit(2'd0, 1'b1, 8'h37, 1'b1, 1'b0);
    check("act_over_inc", 32'(fields), 32'h004237);
    check("pre_wb_dirty", 32'(dirty), 32'h5);

    // write-back with wb_ready high
    sb_q.push_back({2'd0, 8'h37});
    sb_q.push_back({2'd2, 8'h00});
    wb_ready  = 1'b1;
    seleccion = 1'b0;
    tick();
    check("wb1_valid_rise", 32'(wb_valid), 32'h1);
    check("wb1_busy",       32'(wb_busy),  32'h1);
    check("wb1_addr0",      32'(wb_addr),  32'h0);
    tick();
    check("wb1_addr2",      32'(wb_addr),  32'h2);
    check("wb1_valid_b2b",  32'(wb_valid), 32'h1);
    check("wb1_dirty_mid",  32'(dirty),    32'h4);
    tick();
    check("wb1_done",       32'(wb_done),  32'h1);
    check("wb1_valid_low",  32'(wb_valid), 32'h0);
    check("wb1_dirty_clr",  32'(dirty),    32'h0);
    check("wb1_busy_done",  32'(wb_busy),  32'h1);
    tick();
    check("wb1_done_pulse", 32'(wb_done),  32'h0);
    check("wb1_busy_drop",  32'(wb_busy),  32'h0);
    check("wb1_sb_drained", 32'(sb_q.size()), 32'h0);

    // edit session 2
    wb_ready  = 1'b0;
    seleccion = 1'b1;
    tick();
    edit(2'd1, 1'b1, 8'h00, 1'b0, 1'b0);
    edit(2'd1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("dec_wrap_00",  32'(fields), 32'h005937);
    check("dec_dirty_f1", 32'(dirty),  32'h2);
    edit(2'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("dec_plain",    32'(fields), 32'h005936);
    edit(2'd2, 1'b0, 8'h00, 1'b0, 1'b1);
    edit(2'd0, 1'b1, 8'h40, 1'b0, 1'b0);
    edit(2'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("dec_borrow_40", 32'(fields), 32'h235939);
    check("dec_dirty_all", 32'(dirty),  32'h7);

    // write-back under backpressure, then reset mid-sequence
    sb_q.push_back({2'd0, 8'h39});
    seleccion = 1'b0;
    tick();
    check("wb2_valid",  32'(wb_valid), 32'h1);
    check("wb2_data0",  32'(wb_data),  32'h39);
    rtc_valid = 1'b1; rtc_addr = 2'd0; rtc_data = 8'h11;
    tick();
    rtc_valid = 1'b0;
    check("bp1_rtc_blocked", 32'(fields), 32'h235939);
    check("bp1_addr",  32'(wb_addr),  32'h0);
    check("bp1_valid", 32'(wb_valid), 32'h1);
    seleccion = 1'b1; edit_field = 2'd0; edit_inc = 1'b1;
    tick();
    edit_inc = 1'b0;
    check("bp2_edit_blocked", 32'(fields), 32'h235939);
    check("bp2_dirty", 32'(dirty), 32'h7);
    tick();
    check("bp3_valid", 32'(wb_valid), 32'h1);
    check("bp3_data",  32'(wb_data),  32'h39);
    wb_ready  = 1'b1;
    seleccion = 1'b0;
    tick();
    check("wb2_addr1",  32'(wb_addr), 32'h1);
    check("wb2_data1",  32'(wb_data), 32'h59);
    check("wb2_dirty",  32'(dirty),   32'h6);
    wb_ready = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid",  32'(wb_valid), 32'h0);
    check("rst_mid_dirty",  32'(dirty),    32'h0);
    check("rst_mid_fields", 32'(fields),   32'h0);
    check("rst_mid_busy",   32'(wb_busy),  32'h0);
    wb_ready = 1'b1;
    tick();
    check("rst_no_more_beats", 32'(wb_valid), 32'h0);
    check("sb_final_empty", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/time_field_bank.md
# time_field_bank

Parametrised bank of BCD time fields (seconds, minutes, hours by default) between the RTC read/write sequencer and the VGA character generator. Fields load from RTC reads in run mode and from user edits (direct load or BCD increment/decrement with per-field wrap) in edit mode. On leaving edit mode, every edited field is written back to the RTC through a valid/ready handshake. All field contents drive the display continuously.

## Interface
- NUM_FIELDS, 3: number of 8-bit BCD fields; field 0 = seconds, 1 = minutes, 2 = hours.
- AW, 2: field address width; must satisfy 2^AW >= NUM_FIELDS.
- FIELD_MAX, {8'h23,8'h59,8'h59}: packed NUM_FIELDS*8 BCD upper limits, field 0 in bits [7:0]; lower limit is 8'h00 for every field.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- seleccion  in  1  mode: 0 = run (RTC loads), 1 = edit (user changes).
- en_deco  in  1  global update enable; gates RTC loads and edits, not write-back.
- rtc_valid  in  1  RTC read data valid this cycle.
- rtc_addr  in  AW  field index of rtc_data.
- rtc_data  in  8  BCD value read from RTC.
- edit_field  in  AW  field targeted by edit commands.
- act  in  1  direct load of act_data into edit_field.
- act_data  in  8  BCD value for direct load.
- edit_inc  in  1  BCD increment of edit_field.
- edit_dec  in  1  BCD decrement of edit_field.
- wb_ready  in  1  RTC sequencer accepts write-back beat.
- fields  out  NUM_FIELDS*8  current field values, field i in bits [8i+7:8i].
- dirty  out  NUM_FIELDS  field edited, not yet written back.
- wb_valid  out  1  write-back beat valid.
- wb_addr  out  AW  field index of beat.
- wb_data  out  8  field value of beat.
- wb_busy  out  1  write-back sequence in progress.
- wb_done  out  1  one-cycle pulse at end of write-back sequence.

## Operation
- Reset: fields = 0, dirty = 0, wb_valid = 0, wb_addr = 0, wb_data = 0, wb_busy = 0, wb_done = 0, FSM = IDLE, seleccion_q = 0.
- RTC load: en_deco && !seleccion && rtc_valid && !wb_busy && rtc_addr < NUM_FIELDS → field[rtc_addr] <= rtc_data, unchecked. dirty unchanged.
- Edit: en_deco && seleccion && !wb_busy && edit_field < NUM_FIELDS. Priority: act > single inc/dec.
  - act: load act_data only if both nibbles ≤ 9 and value ≤ FIELD_MAX[field]; otherwise no change. A successful load sets dirty.
  - edit_inc && !edit_dec: if value == max → 8'h00; else if low nibble == 9 → low 0, high+1; else low+1. Sets dirty.
  - edit_dec && !edit_inc: if value == 8'h00 → max; else if low nibble == 0 → low 9, high−1; else low−1. Sets dirty.
  - edit_inc && edit_dec with no act: no change, dirty unchanged.
- Out-of-range addresses (≥ NUM_FIELDS) are ignored for both RTC loads and edits.
- Write-back FSM (seleccion_q is seleccion registered each cycle):
  - IDLE: when seleccion_q == 1, seleccion == 0 and |dirty → SEND with idx = lowest set dirty bit. If dirty == 0, stay in IDLE.
  - SEND: wb_valid = 1, wb_addr = idx, wb_data = field[idx]; both are held stable while !wb_ready. On wb_ready, clear dirty[idx]. If other dirty bits remain, stay in SEND with the next lowest idx. Otherwise → DONE.
  - DONE: wb_done = 1 for one cycle → IDLE.
  - wb_busy = (state != IDLE).
- seleccion returning to 1 during SEND/DONE does not abort the sequence. Edits and RTC loads stay blocked until IDLE.
- Reset mid-sequence aborts immediately. No further beats are issued.

## Timing
- Field updates and dirty set are visible 1 cycle after the qualifying input edge.
- wb_valid rises 1 cycle after the cycle in which seleccion == 0 is sampled with seleccion_q == 1.
- One beat per accepted cycle. Back-to-back beats run with wb_valid continuously high. A sequence of k fields with wb_ready tied high takes k cycles in SEND plus 1 cycle in DONE.
- wb_done is asserted in the cycle after the last accepted beat. wb_busy drops in the cycle after wb_done.

## Test plan
- Reset, then RTC load: rtc_valid with addr 1, data 8'h42 in run mode → fields[15:8] = 8'h42 next cycle, dirty = 0. Same load with en_deco = 0 → no change.
- Increment wrap: edit mode, field 0 = 8'h59, edit_inc → 8'h00; field 2 = 8'h19, edit_inc → 8'h20; field 2 = 8'h23, edit_inc → 8'h00. dirty bits set.
- Decrement and conflicts: field 1 = 8'h00, edit_dec → 8'h59. inc+dec together → unchanged. act 8'h37 with inc → 8'h37. act 8'h6A or 8'h60 on field 1 → rejected, dirty unchanged.
- Write-back: dirty = 3'b101, seleccion 1→0, wb_ready high → beats (0, f0), (2, f2) on consecutive cycles, then wb_done pulse; dirty = 0.
- Backpressure: wb_ready low for 3 cycles → wb_addr/wb_data stable, wb_valid held. rtc_valid during wb_busy → ignored.
- Reset asserted during SEND → wb_valid = 0, dirty = 0, fields = 0 the next cycle, FSM in IDLE.
